// File: rtl/cs_resolver_pkg.sv
// cs_resolver_pkg: shared types and helpers for the carry-save resolver.
//   state_e    - FSM encoding (IDLE, ADD, DONE), also driven onto dbg_state
//   num_chunks - ceiling division used to size the chunked datapath
package cs_resolver_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int num_chunks(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/cs_resolver_cpa_chunk.sv
// cpa_chunk: CHUNK-bit ripple-carry adder made of full-adder cells.
// Purely combinational; the resolver feeds it one chunk of each operand
// plus the carry held from the previous chunk.
// Ports:
//   a, b  in  CHUNK  operand chunks
//   cin   in  1      carry from the previous chunk
//   s     out CHUNK  chunk sum
//   cout  out 1      carry into the next chunk
module cpa_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/cs_resolver.sv
// cs_resolver: sequential carry-propagate resolver for the Booth multiplier.
// Turns the redundant (sum, carry) pair from the CSA tree into a binary
// result, sum + (carry << 1), resolving CHUNK bits per cycle.
//
// Optional build macro: CS_RESOLVER_ZERO_SKIP_EN
//   When defined, the adder stops early once the carry dies out and every
//   remaining operand bit is zero. Results are identical either way.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and data stable until that edge and
// never waits for ready before raising valid; ready may depend on state only.
//
// Ports:
//   clk         in  1        clock, rising edge
//   rst_n       in  1        asynchronous active-low reset
//   sum_in      in  WIDTH+3  CSA sum vector
//   carry_in    in  WIDTH+3  CSA carry vector, bit i weighs 2^(i+1)
//   in_valid    in  1        input pair valid
//   in_ready    out 1        resolver accepts (IDLE only, low in reset)
//   result_out  out WIDTH+5  sum_in + (carry_in << 1)
//   out_valid   out 1        result valid (DONE)
//   out_ready   in  1        consumer accepts result
//   dbg_state   out 2        current FSM state (state_e encoding)
module cs_resolver
  import cs_resolver_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH+2:0]   sum_in,
  input  logic [WIDTH+2:0]   carry_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH+4:0]   result_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         dbg_state
);

  localparam int OPW = WIDTH + 4;
  localparam int NC  = num_chunks(OPW, CHUNK);
  localparam int PW  = NC * CHUNK;
  localparam int IW  = (NC > 1) ? $clog2(NC) : 1;

  localparam logic [1:0]    S_IDLE = IDLE;
  localparam logic [1:0]    S_ADD  = ADD;
  localparam logic [1:0]    S_DONE = DONE;
  localparam logic [IW-1:0] LAST   = IW'(NC - 1);

  logic [1:0]       state;
  logic [PW-1:0]    a_q;
  logic [PW-1:0]    b_q;
  // One bit above the padded width catches the final carry; bits above
  // OPW only exist when CHUNK does not divide OPW and are never output.
  logic [PW:0]      res_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;

  int               base;
  logic [CHUNK-1:0] a_k;
  logic [CHUNK-1:0] b_k;
  logic [CHUNK-1:0] r_k;
  logic             c_k;
  logic [PW:0]      res_nxt;
  logic             skip;

  assign base = int'(idx_q) * CHUNK;
  assign a_k  = a_q[base +: CHUNK];
  assign b_k  = b_q[base +: CHUNK];

  cpa_chunk #(.CHUNK(CHUNK)) u_cpa (
    .a    (a_k),
    .b    (b_k),
    .cin  (carry_q),
    .s    (r_k),
    .cout (c_k)
  );

`ifdef CS_RESOLVER_ZERO_SKIP_EN
  logic [PW-1:0] upper;
  logic [PW:0]   keep;
  // Operand bits above the chunk being resolved; if they are all zero and
  // no carry leaves this chunk, every higher result bit is zero too.
  assign upper = (a_q | b_q) >> (base + CHUNK);
  assign keep  = ((PW+1)'(1) << (base + CHUNK)) - (PW+1)'(1);
  assign skip  = !c_k && (upper == '0);
`else
  assign skip  = 1'b0;
`endif

  always_comb begin
    res_nxt = res_q;
    res_nxt[base +: CHUNK] = r_k;
    if (idx_q == LAST) res_nxt[PW] = c_k;
`ifdef CS_RESOLVER_ZERO_SKIP_EN
    // Stale bits from the previous result are cleared when finishing early.
    if (skip) res_nxt = res_nxt & keep;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= PW'({1'b0, sum_in});
            b_q     <= PW'({carry_in, 1'b0});
            carry_q <= 1'b0;
            idx_q   <= '0;
            state   <= S_ADD;
          end
        end
        S_ADD: begin
          res_q   <= res_nxt;
          carry_q <= c_k;
          idx_q   <= idx_q + 1'b1;
          if (skip || idx_q == LAST) state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Gated by rst_n so the upstream sees no ready while reset is held.
  assign in_ready   = (state == S_IDLE) && rst_n;
  assign out_valid  = (state == S_DONE);
  assign result_out = res_q[OPW:0];
  assign dbg_state  = state;

endmodule
